mem_wb_skid: RTL and testbench
==============================

# mem_wb_skid

Parametrised MEM/WB pipeline stage for Osiris I with a valid/ready handshake, a two-entry skid buffer, synchronous flush and asynchronous reset. It sits between the MEM stage and the WB stage and carries the same payload as the plain MEM/WB register. It can absorb one beat of WB back-pressure without combinational ready paths. Full throughput is one instruction per cycle, and the upstream ready is driven only from registers.

## Interface
Parameters:
- DATA_WIDTH, 32, width of ALU result, load data, PC target and PC+4 fields
- REG_WIDTH, 5, width of destination register index

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- i_valid_M  in  1  MEM stage presents a valid instruction
- o_ready_M  out  1  stage can accept a beat this cycle (registered)
- i_alu_result_M  in  DATA_WIDTH  ALU result
- i_read_data_M  in  DATA_WIDTH  load data
- i_pc_target_M  in  DATA_WIDTH  branch/jump target
- i_pc_plus4_M  in  DATA_WIDTH  PC+4
- i_rd_M  in  REG_WIDTH  destination register
- i_reg_write_M  in  1  register-file write enable
- i_result_src_M  in  2  WB result mux select
- i_flush  in  1  synchronous flush, discards all held entries
- o_valid_WB  out  1  WB-side payload is valid
- i_ready_WB  in  1  WB stage consumes the beat
- o_alu_result_WB, o_read_data_WB, o_pc_target_WB, o_pc_plus4_WB  out  DATA_WIDTH  registered payload
- o_rd_WB  out  REG_WIDTH  registered destination
- o_reg_write_WB  out  1  stored reg_write AND o_valid_WB
- o_result_src_WB  out  2  registered result select

## Operation
- Storage: main entry, which drives the outputs, and skid entry. Each entry holds the full payload.
- Accept: acc = i_valid_M & o_ready_M. Release: rel = o_valid_WB & i_ready_WB.
- States, encoded as occupancy:
  - EMPTY: o_valid_WB=0, o_ready_M=1.
  - ONE: main full, o_valid_WB=1, o_ready_M=1.
  - TWO: main and skid full, o_valid_WB=1, o_ready_M=0.
- Transitions when i_flush=0:
  - EMPTY: on acc, load main and go to ONE.
  - ONE: acc&rel loads main, stays ONE. acc&!rel loads skid, goes TWO. !acc&rel goes EMPTY. Neither: hold.
  - TWO: on rel, main<=skid and go to ONE. Otherwise hold. acc cannot occur.
- Flush: i_flush=1 forces the next state to EMPTY and clears the stored reg_write of both entries. It has priority over a simultaneous acc and rel; the accepted beat is dropped. Payload data fields may keep stale values.
- o_reg_write_WB is gated by o_valid_WB, so an invalid stage never writes the register file.
- Payload is never modified in flight. Order is strictly FIFO.

## Timing
- Reset (async assert, sync-safe release): state EMPTY, o_valid_WB=0, o_ready_M=1, all payload outputs 0, o_reg_write_WB=0, o_result_src_WB=2'b00.
- Reset mid-operation discards both entries immediately, without waiting for a clock edge.
- Latency: beat accepted at edge N appears on the outputs after edge N, with o_valid_WB=1 in cycle N+1.
- o_ready_M depends only on state registers, with no combinational path from i_ready_WB.
- Deasserting i_ready_WB for one cycle with continuous input costs zero bubbles. The skid absorbs the beat and o_ready_M drops for one cycle.
- Sustained throughput is 1 beat/cycle whenever i_ready_WB=1.

## Configuration
- MEM_WB_X0_SUPPRESS_EN:
  - Defined: at capture, into main or skid, the stored reg_write is forced to 0 when i_rd_M == 0, so writes to x0 never reach WB.
  - Undefined: reg_write is stored exactly as received.
- Handshake and timing are identical in both builds.

## Test plan
- Reset with rst=1 mid-traffic, then release: outputs zero, o_valid_WB=0, o_ready_M=1, and both held entries are discarded.
- Streaming, i_ready_WB=1, 8 back-to-back beats with alu_result=1..8: outputs 1..8 on consecutive cycles, each one cycle after acceptance, o_ready_M constantly 1.
- Back-pressure, i_ready_WB=0 for 3 cycles while streaming 0xA,0xB,0xC:
  - o_ready_M drops after the second accept.
  - Output holds 0xA.
  - On release, 0xA,0xB,0xC arrive in order with nothing lost or duplicated.
- Flush in state TWO with simultaneous i_valid_M=1: next cycle o_valid_WB=0, o_reg_write_WB=0, and the incoming beat is not delivered.
- Gating: stage EMPTY with a stale stored reg_write=1: o_reg_write_WB=0.
- With MEM_WB_X0_SUPPRESS_EN, send rd=0 with reg_write=1: o_reg_write_WB=0. Send rd=5 with reg_write=1: o_reg_write_WB=1. Without the macro, both give 1.

Source files
------------

// File: rtl/mem_wb_skid.sv
// rtl/mem_wb_skid.sv - MEM/WB pipeline stage with valid/ready handshake and two-entry skid buffer
// Optional MEM_WB_X0_SUPPRESS_EN: drop reg_write at capture when the destination is x0.
module mem_wb_skid #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid_M,
  output logic                  o_ready_M,
  input  logic [DATA_WIDTH-1:0] i_alu_result_M,
  input  logic [DATA_WIDTH-1:0] i_read_data_M,
  input  logic [DATA_WIDTH-1:0] i_pc_target_M,
  input  logic [DATA_WIDTH-1:0] i_pc_plus4_M,
  input  logic [REG_WIDTH-1:0]  i_rd_M,
  input  logic                  i_reg_write_M,
  input  logic [1:0]            i_result_src_M,
  input  logic                  i_flush,
  output logic                  o_valid_WB,
  input  logic                  i_ready_WB,
  output logic [DATA_WIDTH-1:0] o_alu_result_WB,
  output logic [DATA_WIDTH-1:0] o_read_data_WB,
  output logic [DATA_WIDTH-1:0] o_pc_target_WB,
  output logic [DATA_WIDTH-1:0] o_pc_plus4_WB,
  output logic [REG_WIDTH-1:0]  o_rd_WB,
  output logic                  o_reg_write_WB,
  output logic [1:0]            o_result_src_WB
);

  localparam int RW_BIT  = 2;
  localparam int RD_LSB  = 3;
  localparam int P4_LSB  = RD_LSB + REG_WIDTH;
  localparam int TGT_LSB = P4_LSB + DATA_WIDTH;
  localparam int RDD_LSB = TGT_LSB + DATA_WIDTH;
  localparam int ALU_LSB = RDD_LSB + DATA_WIDTH;
  localparam int PW      = ALU_LSB + DATA_WIDTH;

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  state_t          state, state_next;
  logic [PW-1:0]   main_q, skid_q, in_beat;
  logic            acc, rel, in_rw;
  logic            load_main_in, load_skid_in, load_main_skid;

`ifdef MEM_WB_X0_SUPPRESS_EN
  assign in_rw = i_reg_write_M & (i_rd_M != '0);
`else
  assign in_rw = i_reg_write_M;
`endif

  assign in_beat = {i_alu_result_M, i_read_data_M, i_pc_target_M, i_pc_plus4_M,
                    i_rd_M, in_rw, i_result_src_M};

  // Handshake outputs come straight from the occupancy register, never from i_ready_WB.
  assign o_valid_WB = (state != EMPTY);
  assign o_ready_M  = (state != TWO);
  assign acc        = i_valid_M & o_ready_M;
  assign rel        = o_valid_WB & i_ready_WB;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    case (state)
      EMPTY: begin
        if (acc) begin
          load_main_in = 1'b1;
          state_next   = ONE;
        end
      end
      ONE: begin
        if (acc && rel) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          load_skid_in = 1'b1;
          state_next   = TWO;
        end else if (rel) begin
          state_next = EMPTY;
        end
      end
      TWO: begin
        if (rel) begin
          load_main_skid = 1'b1;
          state_next     = ONE;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (i_flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_skid_in   = 1'b0;
      load_main_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else begin
      state <= state_next;
      if (i_flush) begin
        main_q[RW_BIT] <= 1'b0;
        skid_q[RW_BIT] <= 1'b0;
      end else begin
        if (load_main_in)
          main_q <= in_beat;
        else if (load_main_skid)
          main_q <= skid_q;
        if (load_skid_in)
          skid_q <= in_beat;
      end
    end
  end

  assign o_alu_result_WB = main_q[ALU_LSB +: DATA_WIDTH];
  assign o_read_data_WB  = main_q[RDD_LSB +: DATA_WIDTH];
  assign o_pc_target_WB  = main_q[TGT_LSB +: DATA_WIDTH];
  assign o_pc_plus4_WB   = main_q[P4_LSB +: DATA_WIDTH];
  assign o_rd_WB         = main_q[RD_LSB +: REG_WIDTH];
  assign o_reg_write_WB  = main_q[RW_BIT] & o_valid_WB;
  assign o_result_src_WB = main_q[1:0];

endmodule

// File: tb/tb_mem_wb_skid.sv
// tb/tb_mem_wb_skid.sv - self-checking bench for mem_wb_skid against a two-slot FIFO model
module tb_mem_wb_skid;
  localparam int DW = 32;
  localparam int RW = 5;
`ifdef MEM_WB_X0_SUPPRESS_EN
  localparam bit X0_SUP = 1'b1;
`else
  localparam bit X0_SUP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid_M, o_ready_M, i_reg_write_M, i_flush, o_valid_WB, i_ready_WB, o_reg_write_WB;
  logic [DW-1:0] i_alu_result_M, i_read_data_M, i_pc_target_M, i_pc_plus4_M;
  logic [DW-1:0] o_alu_result_WB, o_read_data_WB, o_pc_target_WB, o_pc_plus4_WB;
  logic [RW-1:0] i_rd_M, o_rd_WB;
  logic [1:0]    i_result_src_M, o_result_src_WB;

  typedef struct packed {
    logic [DW-1:0] alu, rdd, tgt, p4;
    logic [RW-1:0] rd;
    logic          rw;
    logic [1:0]    src;
  } beat_t;

  beat_t q[$];
  beat_t nb;
  bit    m_acc, m_rel;
  int    checks = 0;
  int    failures = 0;

  mem_wb_skid #(.DATA_WIDTH(DW), .REG_WIDTH(RW)) dut (
    .clk(clk), .rst(rst),
    .i_valid_M(i_valid_M), .o_ready_M(o_ready_M),
    .i_alu_result_M(i_alu_result_M), .i_read_data_M(i_read_data_M),
    .i_pc_target_M(i_pc_target_M), .i_pc_plus4_M(i_pc_plus4_M),
    .i_rd_M(i_rd_M), .i_reg_write_M(i_reg_write_M), .i_result_src_M(i_result_src_M),
    .i_flush(i_flush), .o_valid_WB(o_valid_WB), .i_ready_WB(i_ready_WB),
    .o_alu_result_WB(o_alu_result_WB), .o_read_data_WB(o_read_data_WB),
    .o_pc_target_WB(o_pc_target_WB), .o_pc_plus4_WB(o_pc_plus4_WB),
    .o_rd_WB(o_rd_WB), .o_reg_write_WB(o_reg_write_WB), .o_result_src_WB(o_result_src_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [RW-1:0] r,
                       input logic w, input logic rdy, input logic fl);
    i_valid_M      = v;
    i_alu_result_M = a;
    i_read_data_M  = a ^ 32'h5a5a_0000;
    i_pc_target_M  = a + 32'h100;
    i_pc_plus4_M   = a + 32'd4;
    i_rd_M         = r;
    i_reg_write_M  = w;
    i_result_src_M = a[1:0];
    i_ready_WB     = rdy;
    i_flush        = fl;
  endtask

  // Reference: a FIFO of at most two beats; flush and reset empty it.
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
    end else begin
      m_acc = i_valid_M && (q.size() < 2);
      m_rel = (q.size() > 0) && i_ready_WB;
      if (i_flush) begin
        q.delete();
      end else begin
        if (m_rel) void'(q.pop_front());
        if (m_acc) begin
          nb.alu = i_alu_result_M;
          nb.rdd = i_read_data_M;
          nb.tgt = i_pc_target_M;
          nb.p4  = i_pc_plus4_M;
          nb.rd  = i_rd_M;
          nb.rw  = i_reg_write_M & ~(X0_SUP & (i_rd_M == '0));
          nb.src = i_result_src_M;
          q.push_back(nb);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("m_valid", o_valid_WB, q.size() > 0);
    chk("m_ready", o_ready_M, q.size() < 2);
    if (q.size() > 0) begin
      chk("m_alu", o_alu_result_WB, q[0].alu);
      chk("m_rdd", o_read_data_WB, q[0].rdd);
      chk("m_tgt", o_pc_target_WB, q[0].tgt);
      chk("m_p4", o_pc_plus4_WB, q[0].p4);
      chk("m_rd", o_rd_WB, q[0].rd);
      chk("m_rw", o_reg_write_WB, q[0].rw);
      chk("m_src", o_result_src_WB, q[0].src);
    end else begin
      chk("m_rw_gate", o_reg_write_WB, 1'b0);
    end
  end

  initial begin
    drive(0, 0, 0, 0, 1, 0);
    repeat (2) @(negedge clk);
    chk("rst_valid", o_valid_WB, 1'b0);
    chk("rst_ready", o_ready_M, 1'b1);
    chk("rst_alu", o_alu_result_WB, 0);
    chk("rst_src", o_result_src_WB, 2'b00);
    rst = 1'b0;

    for (int k = 1; k <= 8; k++) begin
      drive(1, k, 5'(k), 1, 1, 0);
      @(negedge clk);
      chk("stream_alu", o_alu_result_WB, k);
      chk("stream_valid", o_valid_WB, 1'b1);
      chk("stream_ready", o_ready_M, 1'b1);
    end
    drive(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    chk("stream_drain", o_valid_WB, 1'b0);

    drive(1, 32'hA, 1, 1, 0, 0); @(negedge clk);
    chk("bp_a0", o_alu_result_WB, 32'hA); chk("bp_rdy0", o_ready_M, 1'b1);
    drive(1, 32'hB, 2, 1, 0, 0); @(negedge clk);
    chk("bp_a1", o_alu_result_WB, 32'hA); chk("bp_rdy1", o_ready_M, 1'b0);
    drive(1, 32'hC, 3, 1, 0, 0); @(negedge clk);
    chk("bp_a2", o_alu_result_WB, 32'hA); chk("bp_rdy2", o_ready_M, 1'b0);
    drive(1, 32'hC, 3, 1, 1, 0); @(negedge clk);
    chk("bp_b", o_alu_result_WB, 32'hB);
    drive(1, 32'hC, 3, 1, 1, 0); @(negedge clk);
    chk("bp_c", o_alu_result_WB, 32'hC);
    drive(0, 0, 0, 0, 1, 0); @(negedge clk);
    chk("bp_end", o_valid_WB, 1'b0);

    drive(1, 32'h11, 3, 1, 0, 0); @(negedge clk);
    drive(1, 32'h22, 4, 1, 0, 0); @(negedge clk);
    chk("fl_two", o_ready_M, 1'b0);
    drive(1, 32'h33, 6, 1, 1, 1); @(negedge clk);
    chk("fl_valid", o_valid_WB, 1'b0);
    chk("fl_rw", o_reg_write_WB, 1'b0);
    drive(0, 0, 0, 0, 1, 0);
    repeat (2) begin
      @(negedge clk);
      chk("fl_nodeliver", o_valid_WB, 1'b0);
    end

    drive(1, 32'h44, 5, 1, 1, 0); @(negedge clk);
    chk("gate_on", o_reg_write_WB, 1'b1);
    drive(0, 0, 0, 0, 1, 0); @(negedge clk);
    chk("gate_stale", o_reg_write_WB, 1'b0);

    drive(1, 32'h55, 0, 1, 1, 0); @(negedge clk);
    chk("x0_rd0", o_reg_write_WB, X0_SUP ? 1'b0 : 1'b1);
    drive(1, 32'h56, 5, 1, 1, 0); @(negedge clk);
    chk("x0_rd5", o_reg_write_WB, 1'b1);

    drive(1, 32'h77, 7, 1, 0, 0); @(negedge clk);
    drive(1, 32'h78, 8, 1, 0, 0); @(negedge clk);
    drive(0, 0, 0, 0, 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", o_valid_WB, 1'b0);
    chk("arst_ready", o_ready_M, 1'b1);
    chk("arst_alu", o_alu_result_WB, 0);
    chk("arst_rd", o_rd_WB, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("arst_discard", o_valid_WB, 1'b0);
    end

    for (int n = 0; n < 2000; n++) begin
      drive(($urandom % 4) != 0, $urandom, (($urandom % 4) == 0) ? 5'd0 : 5'($urandom),
            $urandom % 2, ($urandom % 4) != 0, ($urandom % 32) == 0);
      i_read_data_M  = $urandom;
      i_pc_target_M  = $urandom;
      i_pc_plus4_M   = $urandom;
      i_result_src_M = 2'($urandom);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
